// File: rtl/ssl_pkg.sv
// rtl/ssl_pkg.sv - shared state encoding, default parameters and byte type for the sector stream loader
package ssl_pkg;

    localparam int          SSL_DEF_SECTOR_BYTES  = 512;
    localparam int          SSL_DEF_LBA_W         = 9;
    localparam int          SSL_DEF_PREAMBLE_LEN  = 10;
    localparam logic [7:0]  SSL_DEF_PREAMBLE_BASE = 8'h30;
    localparam logic [7:0]  SSL_DEF_EOF_BYTE      = 8'h1A;

    typedef logic [7:0] ssl_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_REQ      = 3'd2,
        ST_ACKWAIT  = 3'd3,
        ST_FETCH    = 3'd4,
        ST_SEND     = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } ssl_state_e;

endpackage

// File: rtl/ssl_sd_req.sv
// rtl/ssl_sd_req.sv - sector read request / acknowledge handshake towards the HPS
module ssl_sd_req #(
    parameter int LBA_W = 9
) (
    input  logic             clk_100m,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             req,
    input  logic [LBA_W-1:0] lba,
    input  logic             sd_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             granted,
    output logic             complete
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_REQ  = 2'd1;
    localparam logic [1:0] PH_WAIT = 2'd2;

    logic [1:0] phase;

    // Hold sd_rd until the HPS acks, then wait for the ack to drop before reporting completion.
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= PH_IDLE;
            sd_rd    <= 1'b0;
            sd_lba   <= '0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            if (abort) begin
                phase <= PH_IDLE;
                sd_rd <= 1'b0;
            end else begin
                case (phase)
                    PH_IDLE: if (req) begin
                        phase  <= PH_REQ;
                        sd_rd  <= 1'b1;
                        sd_lba <= lba;
                    end
                    PH_REQ: if (sd_ack) begin
                        phase <= PH_WAIT;
                        sd_rd <= 1'b0;
                    end
                    PH_WAIT: if (!sd_ack) begin
                        phase    <= PH_IDLE;
                        complete <= 1'b1;
                    end
                    default: phase <= PH_IDLE;
                endcase
            end
        end
    end

    assign granted = (phase == PH_WAIT);

endmodule

// File: rtl/sector_stream_loader.sv
// rtl/sector_stream_loader.sv - streams SD sectors byte by byte to a sink; SSL_CHECKSUM_EN adds a running byte sum
module sector_stream_loader
    import ssl_pkg::*;
#(
    parameter int         SECTOR_BYTES  = SSL_DEF_SECTOR_BYTES,
    parameter int         LBA_W         = SSL_DEF_LBA_W,
    parameter int         PREAMBLE_LEN  = SSL_DEF_PREAMBLE_LEN,
    parameter logic [7:0] PREAMBLE_BASE = SSL_DEF_PREAMBLE_BASE,
    parameter logic [7:0] EOF_BYTE      = SSL_DEF_EOF_BYTE
) (
    input  logic                            clk_100m,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [LBA_W-1:0]                base_lba,
    input  logic [LBA_W-1:0]                max_sectors,
    output logic [LBA_W-1:0]                sd_lba,
    output logic                            sd_rd,
    input  logic                            sd_ack,
    output logic [$clog2(SECTOR_BYTES)-1:0] buf_addr,
    input  logic [7:0]                      buf_dout,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [7:0]                      checksum
);

    localparam int AW = $clog2(SECTOR_BYTES);

    ssl_state_e     state;
    logic [LBA_W-1:0] lba;
    logic [LBA_W-1:0] sec_cnt;
    logic [AW-1:0]    idx;
    ssl_byte_t        pre_idx;
    logic             fetch_wait;
    logic             sd_granted;
    logic             sd_complete;

    // Idle-like states are the only ones that accept a new start.
    assign busy = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    ssl_sd_req #(
        .LBA_W (LBA_W)
    ) u_sd_req (
        .clk_100m (clk_100m),
        .reset_n  (reset_n),
        .abort    (abort),
        .req      (state == ST_REQ),
        .lba      (lba),
        .sd_ack   (sd_ack),
        .sd_lba   (sd_lba),
        .sd_rd    (sd_rd),
        .granted  (sd_granted),
        .complete (sd_complete)
    );

    // Byte FSM: preamble, sector request, buffer fetch with one-cycle latency, and valid/ready send.
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            lba        <= '0;
            sec_cnt    <= '0;
            idx        <= '0;
            pre_idx    <= '0;
            fetch_wait <= 1'b0;
            buf_addr   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (abort) begin
            state      <= ST_IDLE;
            tx_valid   <= 1'b0;
            fetch_wait <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: if (start) begin
                    lba     <= base_lba;
                    sec_cnt <= '0;
                    idx     <= '0;
                    pre_idx <= '0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    if (PREAMBLE_LEN == 0) begin
                        state <= ST_REQ;
                    end else begin
                        state    <= ST_PREAMBLE;
                        tx_data  <= PREAMBLE_BASE;
                        tx_valid <= 1'b1;
                    end
                end
                ST_PREAMBLE: if (tx_ready) begin
                    if (pre_idx == 8'(PREAMBLE_LEN - 1)) begin
                        tx_valid <= 1'b0;
                        state    <= ST_REQ;
                    end else begin
                        pre_idx <= pre_idx + 8'd1;
                        tx_data <= PREAMBLE_BASE + pre_idx + 8'd1;
                    end
                end
                ST_REQ: if (sd_granted) begin
                    state <= ST_ACKWAIT;
                end
                ST_ACKWAIT: if (sd_complete) begin
                    idx        <= '0;
                    buf_addr   <= '0;
                    fetch_wait <= 1'b1;
                    state      <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else if (buf_dout == EOF_BYTE) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tx_data  <= buf_dout;
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    if (idx != AW'(SECTOR_BYTES - 1)) begin
                        idx        <= idx + 1'b1;
                        buf_addr   <= idx + 1'b1;
                        fetch_wait <= 1'b1;
                        state      <= ST_FETCH;
                    end else begin
                        idx     <= '0;
                        lba     <= lba + 1'b1;
                        sec_cnt <= sec_cnt + 1'b1;
                        if ((max_sectors != '0) && ((sec_cnt + 1'b1) == max_sectors)) begin
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SSL_CHECKSUM_EN
    logic start_ok;
    logic xfer;

    assign start_ok = start && !abort && !busy;
    assign xfer     = tx_valid && tx_ready;

    // Running mod-256 sum of every byte the sink accepts, restarted with each load.
    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= 8'h00;
        end else if (start_ok) begin
            checksum <= 8'h00;
        end else if (xfer) begin
            checksum <= checksum + tx_data;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_sector_stream_loader.sv
// tb/tb_sector_stream_loader.sv - scoreboard bench for sector_stream_loader
module tb_sector_stream_loader;

    localparam int         SB   = 512;
    localparam int         PL   = 10;
    localparam logic [7:0] PB   = 8'h30;
    localparam logic [7:0] EOFB = 8'h1A;

    logic       clk_100m = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [8:0] base_lba = '0;
    logic [8:0] max_sectors = '0;
    logic [8:0] sd_lba;
    logic       sd_rd;
    logic       sd_ack;
    logic [8:0] buf_addr;
    logic [7:0] buf_dout;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] checksum;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         lba_log[$];
    int         xfer_cnt = 0;
    bit         stall = 1'b0;
    bit         rand_ready = 1'b0;
    bit         model_en = 1'b1;
    int         manual_req = 0;
    int         manual_served = 0;
    int         pat_mode = 0;
    int         eof_pos = -1;
    logic [7:0] chk_model = 8'h00;
    logic [7:0] mem [0:SB-1];

    sector_stream_loader dut (
        .clk_100m    (clk_100m),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .base_lba    (base_lba),
        .max_sectors (max_sectors),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_ack      (sd_ack),
        .buf_addr    (buf_addr),
        .buf_dout    (buf_dout),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .checksum    (checksum)
    );

    always #5 clk_100m = ~clk_100m;

    always @(posedge clk_100m) buf_dout <= mem[buf_addr];

    function automatic logic [7:0] sector_byte(input int lba, input int i);
        logic [7:0] v;
        if (pat_mode == 1) begin
            if (i == 0) return 8'hFF;
            if (i == 1) return 8'h02;
            return EOFB;
        end
        if (i == eof_pos) return EOFB;
        v = 8'(32'h41 + i + 16 * (lba - 5));
        if (v == EOFB) v = 8'h1B;
        return v;
    endfunction

    // HPS model: serves sector reads, or emits a stray ack pulse on request
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_100m);
            if (manual_req != manual_served) begin
                manual_served++;
                sd_ack = 1'b1;
                repeat (3) @(negedge clk_100m);
                sd_ack = 1'b0;
            end else if (model_en && reset_n && sd_rd) begin
                lba_log.push_back(int'(sd_lba));
                for (int i = 0; i < SB; i++) mem[i] = sector_byte(int'(sd_lba), i);
                repeat (3) @(negedge clk_100m);
                sd_ack = 1'b1;
                repeat (2) @(negedge clk_100m);
                sd_ack = 1'b0;
            end
        end
    end

    // Sink: choose ready for the coming edge, then score the byte transferred on that edge
    initial begin
        logic [7:0] e;
        tx_ready = 1'b0;
        forever begin
            @(negedge clk_100m);
            tx_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (reset_n && tx_valid && tx_ready) begin
                xfer_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_byte: got %02h, expected no transfer", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        miscompares++;
                        $display("FAIL tx_byte: got %02h, expected %02h", tx_data, e);
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        chk_model = chk_model + b;
    endtask

    task automatic push_preamble();
        for (int i = 0; i < PL; i++) push_byte(8'(PB + i));
    endtask

    task automatic push_sector(input int lba, input int n);
        for (int i = 0; i < n; i++) push_byte(sector_byte(lba, i));
    endtask

    task automatic pulse_start();
        @(negedge clk_100m) start = 1'b1;
        @(negedge clk_100m) start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_100m);
            if (done || err) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    function automatic logic [7:0] exp_checksum();
`ifdef SSL_CHECKSUM_EN
        return chk_model;
`else
        return 8'h00;
`endif
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk_100m);
        vectors++;
        if ({busy, done, err, sd_rd, tx_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 00000", {busy, done, err, sd_rd, tx_valid});
        end
        vectors++;
        if ({sd_lba, buf_addr, tx_data, checksum} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: got lba=%0h addr=%0h data=%0h chk=%0h, expected all 0",
                     sd_lba, buf_addr, tx_data, checksum);
        end
        @(negedge clk_100m) reset_n = 1'b1;
        repeat (2) @(negedge clk_100m);
    endtask

    task automatic test_eof_stop();
        bit ok;
        int n0;
        base_lba = 9'd5; max_sectors = '0; pat_mode = 0; eof_pos = 3;
        lba_log.delete(); chk_model = 8'h00;
        push_preamble();
        push_sector(5, 3);
        n0 = xfer_cnt;
        pulse_start();
        wait_end(3000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL eof_timeout: got no done/err, expected done"); end
        vectors++;
        if ({done, err, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL eof_flags: got done/err/busy=%b, expected 100", {done, err, busy});
        end
        vectors++;
        if (xfer_cnt - n0 != 13 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL eof_count: got %0d transfers (%0d left), expected 13", xfer_cnt - n0, exp_q.size());
        end
        vectors++;
        if (lba_log.size() != 1 || lba_log[0] != 5) begin
            miscompares++;
            $display("FAIL eof_lba: got %0d requests, first=%0d, expected one at 5",
                     lba_log.size(), (lba_log.size() > 0) ? lba_log[0] : -1);
        end
        vectors++;
        if (checksum !== exp_checksum()) begin
            miscompares++;
            $display("FAIL eof_checksum: got %02h, expected %02h", checksum, exp_checksum());
        end
        repeat (5) @(negedge clk_100m);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL done_hold: got %b, expected 1", done); end
    endtask

    task automatic test_sector_limit();
        bit ok;
        int n0;
        base_lba = 9'd5; max_sectors = 9'd2; pat_mode = 0; eof_pos = -1;
        lba_log.delete(); chk_model = 8'h00;
        push_preamble();
        push_sector(5, SB);
        push_sector(6, SB);
        n0 = xfer_cnt;
        rand_ready = 1'b1;
        pulse_start();
        repeat (100) @(negedge clk_100m);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL limit_busy: got %b, expected 1", busy); end
        pulse_start();
        wait_end(40000, ok);
        rand_ready = 1'b0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL limit_timeout: got no done/err, expected err"); end
        vectors++;
        if ({done, err} !== 2'b01) begin
            miscompares++;
            $display("FAIL limit_flags: got done/err=%b, expected 01", {done, err});
        end
        vectors++;
        if (xfer_cnt - n0 != PL + 2 * SB || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL limit_count: got %0d transfers, expected %0d", xfer_cnt - n0, PL + 2 * SB);
        end
        vectors++;
        if (lba_log.size() != 2 || lba_log[0] != 5 || lba_log[1] != 6) begin
            miscompares++;
            $display("FAIL limit_lba: got %0d requests, expected lba 5 then 6", lba_log.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found;
        int n0;
        base_lba = 9'd5; max_sectors = '0; pat_mode = 0; eof_pos = 6;
        lba_log.delete(); chk_model = 8'h00;
        push_preamble();
        push_sector(5, 6);
        n0 = xfer_cnt;
        pulse_start();
        vectors++;
        if ({done, err, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL restart_flags: got done/err/busy=%b, expected 001", {done, err, busy});
        end
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(posedge clk_100m); #1;
            if (tx_valid && tx_data == 8'h42) found = 1'b1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL stall_setup: got no byte 42, expected one"); end
        stall = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk_100m); #1;
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%b data=%02h, expected 1/42", tx_valid, tx_data);
            end
        end
        stall = 1'b0;
        wait_end(3000, ok);
        vectors++;
        if (!ok || done !== 1'b1 || xfer_cnt - n0 != 16 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_count: got done=%b transfers=%0d, expected 1/16", done, xfer_cnt - n0);
        end
    endtask

    task automatic test_abort();
        bit found;
        base_lba = 9'd9; max_sectors = '0; pat_mode = 0; eof_pos = -1;
        lba_log.delete(); chk_model = 8'h00;
        model_en = 1'b0;
        push_preamble();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk_100m);
            if (sd_rd) found = 1'b1;
        end
        vectors++;
        if (!found || sd_lba !== 9'd9) begin
            miscompares++;
            $display("FAIL abort_setup: got sd_rd=%b lba=%0d, expected 1/9", sd_rd, sd_lba);
        end
        abort = 1'b1;
        @(negedge clk_100m) abort = 1'b0;
        vectors++;
        if ({busy, sd_rd, tx_valid, done, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy/rd/valid/done/err=%b, expected 00000",
                     {busy, sd_rd, tx_valid, done, err});
        end
        manual_req++;
        repeat (8) @(negedge clk_100m);
        vectors++;
        if ({busy, sd_rd, done, err} !== 4'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_stray_ack: got busy/rd/done/err=%b, expected 0000", {busy, sd_rd, done, err});
        end
        model_en = 1'b1;
    endtask

    task automatic test_async_reset();
        bit ok;
        bit found;
        logic [7:0] tgt;
        base_lba = 9'd7; max_sectors = '0; pat_mode = 0; eof_pos = 40;
        lba_log.delete(); chk_model = 8'h00;
        push_preamble();
        push_sector(7, 40);
        tgt = sector_byte(7, 4);
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(posedge clk_100m); #1;
            if (tx_valid && tx_data == tgt) found = 1'b1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL areset_setup: got no byte %02h, expected one", tgt); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, tx_valid, sd_rd, done, err} !== 5'b0 || {tx_data, sd_lba, buf_addr} !== '0) begin
            miscompares++;
            $display("FAIL areset_outputs: got busy=%b valid=%b data=%02h addr=%0h, expected all 0",
                     busy, tx_valid, tx_data, buf_addr);
        end
        exp_q.delete();
        repeat (3) @(negedge clk_100m);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_100m);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_idle: got busy=%b, expected 0", busy); end
        lba_log.delete(); eof_pos = 2; chk_model = 8'h00;
        push_preamble();
        push_sector(7, 2);
        pulse_start();
        wait_end(3000, ok);
        vectors++;
        if (!ok || done !== 1'b1 || lba_log.size() != 1 || lba_log[0] != 7 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL areset_rerun: got done=%b requests=%0d, expected 1 and one read at 7",
                     done, lba_log.size());
        end
    endtask

    task automatic test_checksum();
        bit ok;
        int n0;
        base_lba = 9'd3; max_sectors = '0; pat_mode = 1; eof_pos = -1;
        lba_log.delete(); chk_model = 8'h00;
        push_preamble();
        push_byte(8'hFF);
        push_byte(8'h02);
        n0 = xfer_cnt;
        pulse_start();
        wait_end(3000, ok);
        vectors++;
        if (!ok || done !== 1'b1 || xfer_cnt - n0 != PL + 2) begin
            miscompares++;
            $display("FAIL chk_run: got done=%b transfers=%0d, expected 1/%0d", done, xfer_cnt - n0, PL + 2);
        end
        vectors++;
        if (checksum !== exp_checksum()) begin
            miscompares++;
            $display("FAIL chk_value: got %02h, expected %02h", checksum, exp_checksum());
        end
        pat_mode = 0;
    endtask

    initial begin
        test_reset();
        test_eof_stop();
        test_sector_limit();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
